// File: rtl/lsu_io_pkg.sv
// Shared definitions for the LSU input peripheral: read-port word addresses
// and the read-data width.
package lsu_io_pkg;

  localparam int IO_DATA_W = 32;

  typedef enum logic [1:0] {
    IO_SW       = 2'd0,
    IO_BTN      = 2'd1,
    IO_BTN_FLAG = 2'd2,
    IO_RSVD     = 2'd3
  } io_addr_e;

endpackage

// File: rtl/io_sync_chain.sv
// Generic multi-flop synchroniser. Each bit of din passes through STAGES
// flops before it appears on dout; all flops clear on async active-low reset.
module io_sync_chain #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [STAGES];

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= din;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout = stage_q[STAGES-1];

endmodule

// File: rtl/lsu_input_sync_buffer.sv
// LSU input peripheral: synchronises switches and buttons, derives a button
// level (optionally debounced), keeps sticky rising-edge flags with
// read-to-clear, and serves a registered 32-bit read port.
// Optional feature macro: LSU_INPUT_DEBOUNCE_EN (per-button debounce counters).
module lsu_input_sync_buffer
  import lsu_io_pkg::*;
#(
  parameter int SW_WIDTH    = 32,
  parameter int BTN_WIDTH   = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [SW_WIDTH-1:0]  i_io_sw,
  input  logic [BTN_WIDTH-1:0] i_io_btn,
  input  logic                 i_rd_en,
  input  logic [1:0]           i_addr,
  output logic [31:0]          o_rdata,
  output logic                 o_rvalid,
  output logic                 o_btn_irq
);

  // Parameter range guard, evaluated at elaboration only.
  if (SW_WIDTH < 1 || SW_WIDTH > IO_DATA_W || BTN_WIDTH < 1 || BTN_WIDTH > IO_DATA_W ||
      SYNC_STAGES < 2 || DB_CYCLES < 1) begin : g_param_check
    $error("lsu_input_sync_buffer: parameter out of range");
  end

  logic [SW_WIDTH-1:0]  sw_s;
  logic [BTN_WIDTH-1:0] btn_s;
  logic [BTN_WIDTH-1:0] btn_lvl;
  logic [BTN_WIDTH-1:0] btn_prev;
  logic [BTN_WIDTH-1:0] btn_rise;
  logic [BTN_WIDTH-1:0] btn_flag;
  logic                 flag_clr;
  logic [IO_DATA_W-1:0] rd_word;
  logic [IO_DATA_W-1:0] rdata_p1;
  logic                 vld_p1;

  io_sync_chain #(.WIDTH(SW_WIDTH), .STAGES(SYNC_STAGES)) u_sw_sync (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .din   (i_io_sw),
    .dout  (sw_s)
  );

  io_sync_chain #(.WIDTH(BTN_WIDTH), .STAGES(SYNC_STAGES)) u_btn_sync (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .din   (i_io_btn),
    .dout  (btn_s)
  );

`ifdef LSU_INPUT_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [CNT_W-1:0] db_cnt [BTN_WIDTH];

  // Debounce: the level follows btn_s only after DB_CYCLES consecutive cycles of disagreement.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      btn_lvl <= '0;
      for (int i = 0; i < BTN_WIDTH; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < BTN_WIDTH; i++) begin
        if (btn_s[i] == btn_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_LAST) begin
          btn_lvl[i] <= ~btn_lvl[i];
          db_cnt[i]  <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end
`else
  // No debounce: the level is the synchronised button delayed by one cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) btn_lvl <= '0;
    else          btn_lvl <= btn_s;
  end
`endif

  assign btn_rise = btn_lvl & ~btn_prev;
  assign flag_clr = i_rd_en && (i_addr == IO_BTN_FLAG);

  // Edge capture: a rising edge on the same cycle as a clearing read keeps the flag set.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      btn_prev <= '0;
      btn_flag <= '0;
    end else begin
      btn_prev <= btn_lvl;
      btn_flag <= (flag_clr ? '0 : btn_flag) | btn_rise;
    end
  end

  assign o_btn_irq = |btn_flag;

  // Read word select; unused upper bits are zero.
  always_comb begin
    rd_word = '0;
    case (i_addr)
      IO_SW:       rd_word[SW_WIDTH-1:0]  = sw_s;
      IO_BTN:      rd_word[BTN_WIDTH-1:0] = btn_lvl;
      IO_BTN_FLAG: rd_word[BTN_WIDTH-1:0] = btn_flag;
      default:     rd_word = '0;
    endcase
  end

  // ---- stage p1: registered read data and its valid ----
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rdata_p1 <= '0;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= i_rd_en;
      if (i_rd_en) rdata_p1 <= rd_word;
    end
  end

  assign o_rdata  = rdata_p1;
  assign o_rvalid = vld_p1;

endmodule

// File: tb/tb_lsu_input_sync_buffer.sv
// Directed testbench for lsu_input_sync_buffer: vector table plus
// hand-written multi-cycle sequences. Honours LSU_INPUT_DEBOUNCE_EN.
module tb_lsu_input_sync_buffer;

  localparam int SW_W   = 32;
  localparam int BTN_W  = 4;
  localparam int SYNC   = 2;
  localparam int DB     = 16;
  localparam int SETTLE = 24;
`ifdef LSU_INPUT_DEBOUNCE_EN
  localparam int RISE_LAT = SYNC + DB;
`else
  localparam int RISE_LAT = SYNC + 1;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [SW_W-1:0]   sw;
  logic [BTN_W-1:0]  btn;
  logic              rd_en;
  logic [1:0]        addr;
  logic [31:0]       rdata;
  logic              rvalid;
  logic              irq;

  int total = 0;
  int bad   = 0;

  lsu_input_sync_buffer #(
    .SW_WIDTH(SW_W), .BTN_WIDTH(BTN_W), .SYNC_STAGES(SYNC), .DB_CYCLES(DB)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_io_sw   (sw),
    .i_io_btn  (btn),
    .i_rd_en   (rd_en),
    .i_addr    (addr),
    .o_rdata   (rdata),
    .o_rvalid  (rvalid),
    .o_btn_irq (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] sw;
    logic [3:0]  btn;
    logic [1:0]  addr;
    logic        exp_irq;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_read(input logic [1:0] a);
    rd_en = 1'b1;
    addr  = a;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [1:0] a, input logic [31:0] exp);
    do_read(a);
    check({name, "_data"}, rdata, exp);
    check({name, "_vld"}, {31'd0, rvalid}, 32'd1);
  endtask

  initial begin
    vecs[0]  = '{32'hA5A5_5A5A, 4'b0000, 2'd0, 1'b0, 32'hA5A5_5A5A};
    vecs[1]  = '{32'hFFFF_FFFF, 4'b0000, 2'd0, 1'b0, 32'hFFFF_FFFF};
    vecs[2]  = '{32'h0000_0000, 4'b1010, 2'd1, 1'b1, 32'h0000_000A};
    vecs[3]  = '{32'h0000_0000, 4'b1010, 2'd2, 1'b1, 32'h0000_000A};
    vecs[4]  = '{32'h0000_0000, 4'b1010, 2'd2, 1'b0, 32'h0000_0000};
    vecs[5]  = '{32'h1234_5678, 4'b0000, 2'd2, 1'b0, 32'h0000_0000};
    vecs[6]  = '{32'h1234_5678, 4'b0000, 2'd3, 1'b0, 32'h0000_0000};
    vecs[7]  = '{32'hDEAD_BEEF, 4'b1111, 2'd3, 1'b1, 32'h0000_0000};
    vecs[8]  = '{32'hDEAD_BEEF, 4'b1111, 2'd2, 1'b1, 32'h0000_000F};
    vecs[9]  = '{32'hDEAD_BEEF, 4'b1111, 2'd1, 1'b0, 32'h0000_000F};
    vecs[10] = '{32'hDEAD_BEEF, 4'b1111, 2'd0, 1'b0, 32'hDEAD_BEEF};
    vecs[11] = '{32'hDEAD_BEEF, 4'b0000, 2'd2, 1'b0, 32'h0000_0000};

    // Reset held with all inputs high and reads requested.
    rst_n = 1'b0;
    sw    = 32'hFFFF_FFFF;
    btn   = 4'hF;
    rd_en = 1'b1;
    addr  = 2'd0;
    #1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rst_rdata", rdata, 32'h0);
      check("rst_rvalid", {31'd0, rvalid}, 32'h0);
      check("rst_irq", {31'd0, irq}, 32'h0);
    end
    sw    = '0;
    btn   = '0;
    rd_en = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (SETTLE) tick();

    // Vector table.
    for (int v = 0; v < 12; v++) begin
      sw  = vecs[v].sw;
      btn = vecs[v].btn;
      repeat (SETTLE) tick();
      check($sformatf("v%0d_irq", v), {31'd0, irq}, {31'd0, vecs[v].exp_irq});
      read_check($sformatf("v%0d", v), vecs[v].addr, vecs[v].exp);
      tick();
      check($sformatf("v%0d_vld_drop", v), {31'd0, rvalid}, 32'd0);
      check($sformatf("v%0d_hold", v), rdata, vecs[v].exp);
    end

    // Switch synchroniser latency with back-to-back reads.
    sw = '0;
    repeat (SETTLE) tick();
    sw = 32'h0000_0003;
    tick();
    rd_en = 1'b1;
    addr  = 2'd0;
    tick();
    check("sync_early", rdata, 32'h0);
    tick();
    rd_en = 1'b0;
    check("sync_ontime", rdata, 32'h3);
    check("sync_b2b_vld", {31'd0, rvalid}, 32'd1);

    // Button edge flag and read-to-clear.
    btn = 4'b0100;
    repeat (SETTLE) tick();
    check("edge_irq_set", {31'd0, irq}, 32'd1);
    read_check("edge_rd1", 2'd2, 32'h4);
    check("edge_irq_clr", {31'd0, irq}, 32'd0);
    read_check("edge_rd2", 2'd2, 32'h0);

    // Set/clear collision: read issued in the cycle btn_lvl[1] rises.
    btn = 4'b0000;
    repeat (SETTLE) tick();
    btn = 4'b0100;
    repeat (SETTLE) tick();
    btn = 4'b0110;
    repeat (RISE_LAT) tick();
    read_check("coll_rd1", 2'd2, 32'h4);
    check("coll_irq", {31'd0, irq}, 32'd1);
    read_check("coll_rd2", 2'd2, 32'h2);
    read_check("coll_rd3", 2'd2, 32'h0);

    // Short pulse on btn[0].
    btn = 4'b0000;
    repeat (SETTLE) tick();
    read_check("pulse_pre", 2'd2, 32'h0);
`ifdef LSU_INPUT_DEBOUNCE_EN
    btn = 4'b0001;
    repeat (5) tick();
    btn = 4'b0000;
    repeat (SETTLE) tick();
    read_check("db_glitch_lvl", 2'd1, 32'h0);
    read_check("db_glitch_flag", 2'd2, 32'h0);
    btn = 4'b0001;
    repeat (40) tick();
    read_check("db_hold_lvl", 2'd1, 32'h1);
    read_check("db_hold_flag", 2'd2, 32'h1);
`else
    btn = 4'b0001;
    tick();
    btn = 4'b0000;
    repeat (SETTLE) tick();
    read_check("pulse_lvl", 2'd1, 32'h0);
    read_check("pulse_flag", 2'd2, 32'h1);
`endif

    // Mid-operation asynchronous reset with all flags set.
    btn = 4'b0000;
    repeat (SETTLE) tick();
    btn = 4'hF;
    repeat (SETTLE) tick();
    check("mid_irq_before", {31'd0, irq}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_irq_async", {31'd0, irq}, 32'd0);
    check("mid_rdata_async", rdata, 32'h0);
    tick();
    rst_n = 1'b1;
    read_check("mid_rd_after", 2'd2, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
